// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, funct codes, ALU ops, reg_dst encodings,
// the control bundle and the decode-stage FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       jump;
    logic       jump_link;
    logic       jump_reg;
    logic       branch;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [2:0] alu_op;
    logic       is_syscall;
    logic       illegal;
  } ctrl_t;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

endpackage

// File: rtl/mips_decode_stage_if.sv
// Fetch-side, execute-side and hazard signals of the decode stage.
// Optional DECODE_PERF_CNT_EN adds the performance counter outputs.
interface mips_decode_stage_if #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 3
);
  logic              in_valid, in_ready, flush, ex_memread, out_valid, out_ready;
  logic [XLEN-1:0]   instr_in, pc_in, vreg, out_pc, imm_ext;
  logic [REG_AW-1:0] ex_rt, rs, rt, rd;
  logic [1:0]        reg_dst;
  logic              jump, jump_link, jump_reg, branch, branch_ne;
  logic              mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [ALUOP_W-1:0] alu_op;
  logic              is_syscall, illegal, halted;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0]       stall_cnt, bubble_cnt, illegal_cnt;
`endif

  modport slave (
    input  in_valid, instr_in, pc_in, flush, ex_memread, ex_rt, vreg, out_ready,
    output in_ready, out_valid, out_pc, rs, rt, rd, imm_ext, reg_dst,
           jump, jump_link, jump_reg, branch, branch_ne, mem_read, mem_to_reg,
           mem_write, alu_src, reg_write, alu_op, is_syscall, illegal, halted
`ifdef DECODE_PERF_CNT_EN
    , output stall_cnt, bubble_cnt, illegal_cnt
`endif
  );

  modport master (
    output in_valid, instr_in, pc_in, flush, ex_memread, ex_rt, vreg, out_ready,
    input  in_ready, out_valid, out_pc, rs, rt, rd, imm_ext, reg_dst,
           jump, jump_link, jump_reg, branch, branch_ne, mem_read, mem_to_reg,
           mem_write, alu_src, reg_write, alu_op, is_syscall, illegal, halted
`ifdef DECODE_PERF_CNT_EN
    , input stall_cnt, bubble_cnt, illegal_cnt
`endif
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational decoder: opcode/funct/imm16 to control bundle, extended immediate
// and whether the instruction reads rt (used for load-use hazard detection).
module mips_ctrl_decode
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      op,
  input  logic [15:0]     imm16,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm_ext,
  output logic            reads_rt
);
  logic [5:0] funct;
  assign funct = imm16[5:0];

  always_comb begin
    unique case (op)
      OP_ORI:  imm_ext = {{(XLEN-16){1'b0}}, imm16};
      OP_LUI:  imm_ext = XLEN'({imm16, 16'h0000});
      default: imm_ext = {{(XLEN-16){imm16[15]}}, imm16};
    endcase
  end

  always_comb begin
    ctrl     = '0;
    reads_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        reads_rt = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: begin ctrl.reg_dst = REGDST_RD; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
          FN_SUB:          begin ctrl.reg_dst = REGDST_RD; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB; end
          FN_AND:          begin ctrl.reg_dst = REGDST_RD; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
          FN_OR:           begin ctrl.reg_dst = REGDST_RD; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  end
          FN_SLT:          begin ctrl.reg_dst = REGDST_RD; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT; end
          FN_JR:           ctrl.jump_reg   = 1'b1;
          FN_SYSCALL:      ctrl.is_syscall = 1'b1;
          default:         ctrl.illegal    = 1'b1;
        endcase
      end
      OP_J:   ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump = 1'b1; ctrl.jump_link = 1'b1; ctrl.reg_write = 1'b1; ctrl.reg_dst = REGDST_RA;
      end
      OP_BEQ: begin reads_rt = 1'b1; ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB; end
      OP_BNE: begin reads_rt = 1'b1; ctrl.branch = 1'b1; ctrl.branch_ne = 1'b1; ctrl.alu_op = ALU_SUB; end
      OP_ADDI, OP_ADDIU, OP_LUI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
      OP_ORI:   begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  end
      OP_SLTIU: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLT; end
      OP_LW: begin
        ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD;
      end
      OP_SW: begin reads_rt = 1'b1; ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; ctrl.alu_op = ALU_ADD; end
      default: ctrl.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/mips_decode_stage.sv
// Registered decode stage: one-cycle latency, load-use stall, flush, sticky SYSCALL-exit halt.
// Optional DECODE_PERF_CNT_EN adds saturating stall/bubble/illegal counters.
module mips_decode_stage
  import mips_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          REG_AW    = 5,
  parameter int          ALUOP_W   = 3,
  parameter int unsigned EXIT_CODE = 10
) (
  input logic              clk,
  input logic              reset,
  mips_decode_stage_if.slave bus
);
  ctrl_t             dec_ctrl, ctrl_q;
  logic [XLEN-1:0]   dec_imm, imm_q, pc_q;
  logic [REG_AW-1:0] in_rs, in_rt, in_rd, rs_q, rt_q, rd_q;
  logic              reads_rt, hazard, down_free, accept, out_valid_q;
  state_t            state, state_nxt;

  mips_ctrl_decode #(.XLEN(XLEN)) u_ctrl_decode (
    .op       (bus.instr_in[31:26]),
    .imm16    (bus.instr_in[15:0]),
    .ctrl     (dec_ctrl),
    .imm_ext  (dec_imm),
    .reads_rt (reads_rt)
  );

  assign in_rs = REG_AW'(bus.instr_in[25:21]);
  assign in_rt = REG_AW'(bus.instr_in[20:16]);
  assign in_rd = REG_AW'(bus.instr_in[15:11]);

  assign hazard = bus.ex_memread && (bus.ex_rt != '0) &&
                  ((bus.ex_rt == in_rs) || (reads_rt && (bus.ex_rt == in_rt)));
  assign down_free = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // accept already excludes flush, so a flushed exit SYSCALL never halts.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (accept && dec_ctrl.is_syscall && (bus.vreg == XLEN'(EXIT_CODE))) state_nxt = ST_HALT;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == ST_RUN) && !hazard && !bus.flush && down_free;
    bus.halted   = (state == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= dec_ctrl;
      imm_q       <= dec_imm;
      pc_q        <= bus.pc_in;
      rs_q        <= in_rs;
      rt_q        <= in_rt;
      rd_q        <= in_rd;
    end else if (down_free) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_pc     = pc_q;
  assign bus.rs         = rs_q;
  assign bus.rt         = rt_q;
  assign bus.rd         = rd_q;
  assign bus.imm_ext    = imm_q;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.jump       = ctrl_q.jump;
  assign bus.jump_link  = ctrl_q.jump_link;
  assign bus.jump_reg   = ctrl_q.jump_reg;
  assign bus.branch     = ctrl_q.branch;
  assign bus.branch_ne  = ctrl_q.branch_ne;
  assign bus.mem_read   = ctrl_q.mem_read;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.alu_src    = ctrl_q.alu_src;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.alu_op     = ALUOP_W'(ctrl_q.alu_op);
  assign bus.is_syscall = ctrl_q.is_syscall;
  assign bus.illegal    = ctrl_q.illegal;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q, illegal_cnt_q;
  logic        bubble;

  // A bubble is a hazard stall that would otherwise have advanced the pipe.
  assign bubble = bus.in_valid && hazard && !bus.flush && (state == ST_RUN) && down_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q   <= '0;
      bubble_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (bus.in_valid && hazard && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bubble && (bubble_cnt_q != '1))                bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (accept && dec_ctrl.illegal && (illegal_cnt_q != '1)) illegal_cnt_q <= illegal_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.bubble_cnt  = bubble_cnt_q;
  assign bus.illegal_cnt = illegal_cnt_q;
`endif
endmodule

// File: tb/tb_mips_decode_stage.sv
// Directed-vector bench for mips_decode_stage with hand-computed expectations.
module tb_mips_decode_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mips_decode_stage_if #(.XLEN(32), .REG_AW(5), .ALUOP_W(3)) dif ();

  mips_decode_stage #(.XLEN(32), .REG_AW(5), .ALUOP_W(3), .EXIT_CODE(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    dif.instr_in = instr;
    dif.pc_in    = pc;
    dif.in_valid = 1'b1;
    #1 chk("send_in_ready", 32'(dif.in_ready), 32'd1);
    cyc();
    dif.in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    dif.in_valid = 0; dif.instr_in = 0; dif.pc_in = 0; dif.flush = 0;
    dif.ex_memread = 0; dif.ex_rt = 0; dif.vreg = 0; dif.out_ready = 1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_out_valid", 32'(dif.out_valid), 0);
    chk("rst_halted",    32'(dif.halted), 0);
    chk("rst_imm",       dif.imm_ext, 0);
    chk("rst_reg_write", 32'(dif.reg_write), 0);

    // ADDI $8,$0,10
    send(32'h2008000A, 32'h100);
    chk("addi_vld",     32'(dif.out_valid), 1);
    chk("addi_alu_op",  32'(dif.alu_op), 3'b010);
    chk("addi_alu_src", 32'(dif.alu_src), 1);
    chk("addi_regwr",   32'(dif.reg_write), 1);
    chk("addi_imm",     dif.imm_ext, 32'h0000000A);
    chk("addi_rt",      32'(dif.rt), 8);
    chk("addi_pc",      dif.out_pc, 32'h100);

    // Backpressure while ORI $9,$8,0xFFFF is offered
    dif.out_ready = 0; dif.instr_in = 32'h3509FFFF; dif.pc_in = 32'h104; dif.in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 32'(dif.in_ready), 0);
      cyc();
      chk("bp_vld", 32'(dif.out_valid), 1);
      chk("bp_imm", dif.imm_ext, 32'h0000000A);
      chk("bp_pc",  dif.out_pc, 32'h100);
    end
    dif.out_ready = 1;
    send(32'h3509FFFF, 32'h104);
    chk("ori_vld",    32'(dif.out_valid), 1);
    chk("ori_alu_op", 32'(dif.alu_op), 3'b001);
    chk("ori_imm",    dif.imm_ext, 32'h0000FFFF);
    chk("ori_pc",     dif.out_pc, 32'h104);

    // Load-use hazard on rs: ADD $9,$8,$10 behind LW $8
    dif.ex_memread = 1; dif.ex_rt = 8; dif.instr_in = 32'h010A4820; dif.pc_in = 32'h108; dif.in_valid = 1;
    #1 chk("haz_in_ready", 32'(dif.in_ready), 0);
    cyc();
    chk("haz_bubble", 32'(dif.out_valid), 0);
    dif.ex_rt = 10;
    #1 chk("haz_rt_in_ready", 32'(dif.in_ready), 0);
    dif.ex_memread = 0;
    send(32'h010A4820, 32'h108);
    chk("add_vld",     32'(dif.out_valid), 1);
    chk("add_reg_dst", 32'(dif.reg_dst), 1);
    chk("add_regwr",   32'(dif.reg_write), 1);
    chk("add_alu_op",  32'(dif.alu_op), 3'b010);
    chk("add_rd",      32'(dif.rd), 9);
    chk("add_rs",      32'(dif.rs), 8);
    chk("add_rt",      32'(dif.rt), 10);
    // ADDI does not read rt, and ex_rt==0 never stalls
    dif.ex_memread = 1; dif.ex_rt = 9; dif.instr_in = 32'h20090005; dif.in_valid = 1;
    #1 chk("nohaz_rt_unread", 32'(dif.in_ready), 1);
    dif.ex_rt = 0; dif.instr_in = 32'h00000020;
    #1 chk("nohaz_r0", 32'(dif.in_ready), 1);
    dif.ex_memread = 0; dif.in_valid = 0;

    // Flush while BEQ $8,$9,4 is held downstream; LW offered meanwhile
    send(32'h11090004, 32'h10C);
    chk("beq_branch", 32'(dif.branch), 1);
    chk("beq_alu_op", 32'(dif.alu_op), 3'b110);
    chk("beq_bne",    32'(dif.branch_ne), 0);
    dif.out_ready = 0; dif.instr_in = 32'h8D0A0004; dif.pc_in = 32'h110; dif.in_valid = 1;
    cyc();
    chk("beq_held", 32'(dif.branch), 1);
    dif.flush = 1; dif.out_ready = 1;
    #1 chk("flush_in_ready", 32'(dif.in_ready), 0);
    cyc();
    chk("flush_vld", 32'(dif.out_valid), 0);
    dif.flush = 0; dif.in_valid = 0;
    cyc();
    chk("flush_not_acc", 32'(dif.out_valid), 0);
    send(32'h8D0A0004, 32'h110);
    chk("lw_memrd",  32'(dif.mem_read), 1);
    chk("lw_m2r",    32'(dif.mem_to_reg), 1);
    chk("lw_regwr",  32'(dif.reg_write), 1);
    chk("lw_pc",     dif.out_pc, 32'h110);

    send(32'h15090004, 32'h114);
    chk("bne_bne", 32'(dif.branch_ne), 1);
    send(32'hAD0AFFFC, 32'h118);
    chk("sw_memwr", 32'(dif.mem_write), 1);
    chk("sw_regwr", 32'(dif.reg_write), 0);
    chk("sw_imm",   dif.imm_ext, 32'hFFFFFFFC);
    send(32'h3C081234, 32'h11C);
    chk("lui_imm",    dif.imm_ext, 32'h12340000);
    chk("lui_alu_op", 32'(dif.alu_op), 3'b010);
    send(32'h0C000010, 32'h120);
    chk("jal_jump",    32'(dif.jump), 1);
    chk("jal_link",    32'(dif.jump_link), 1);
    chk("jal_reg_dst", 32'(dif.reg_dst), 2);
    chk("jal_regwr",   32'(dif.reg_write), 1);
    send(32'h03E00008, 32'h124);
    chk("jr_jreg",  32'(dif.jump_reg), 1);
    chk("jr_regwr", 32'(dif.reg_write), 0);
    send(32'h2D09000F, 32'h128);
    chk("sltiu_alu_op", 32'(dif.alu_op), 3'b111);

    // Illegal opcode 0x3F, then illegal funct
    send(32'hFC000000, 32'h12C);
    chk("ill_vld",   32'(dif.out_valid), 1);
    chk("ill_flag",  32'(dif.illegal), 1);
    chk("ill_ctrl",  {20'd0, dif.reg_dst, dif.jump, dif.jump_link, dif.jump_reg, dif.branch,
                      dif.mem_read, dif.mem_write, dif.alu_src, dif.reg_write, dif.alu_op}, 0);
`ifdef DECODE_PERF_CNT_EN
    chk("ill_cnt", dif.illegal_cnt, 1);
`endif
    send(32'h0000003F, 32'h130);
    chk("ill_fn_flag",  32'(dif.illegal), 1);
    chk("ill_fn_regwr", 32'(dif.reg_write), 0);

    // SYSCALL with $v0=4: no halt
    dif.vreg = 4;
    send(32'h0000000C, 32'h134);
    chk("sys4_sc",     32'(dif.is_syscall), 1);
    chk("sys4_halted", 32'(dif.halted), 0);
    dif.in_valid = 1; dif.instr_in = 32'h2008000A;
    #1 chk("sys4_ready", 32'(dif.in_ready), 1);
    dif.in_valid = 0;

    // Exit SYSCALL together with flush: flush wins
    dif.vreg = 10; dif.instr_in = 32'h0000000C; dif.in_valid = 1; dif.flush = 1;
    cyc();
    chk("sysfl_halted", 32'(dif.halted), 0);
    chk("sysfl_vld",    32'(dif.out_valid), 0);
    dif.flush = 0;

    // Exit SYSCALL: halt on acceptance, bundle drains, stage stays closed
    send(32'h0000000C, 32'h138);
    chk("exit_vld",    32'(dif.out_valid), 1);
    chk("exit_sc",     32'(dif.is_syscall), 1);
    chk("exit_halted", 32'(dif.halted), 1);
    chk("exit_regwr",  32'(dif.reg_write), 0);
    dif.in_valid = 1; dif.instr_in = 32'h2008000A;
    for (int i = 0; i < 3; i++) begin
      #1 chk("halt_in_ready", 32'(dif.in_ready), 0);
      cyc();
      chk("halt_vld",    32'(dif.out_valid), 0);
      chk("halt_sticky", 32'(dif.halted), 1);
    end
    dif.in_valid = 0;
    reset = 1;
    cyc();
    reset = 0;
    chk("rst2_halted", 32'(dif.halted), 0);
    chk("rst2_sc",     32'(dif.is_syscall), 0);
    dif.in_valid = 1;
    #1 chk("rst2_ready", 32'(dif.in_ready), 1);
    dif.in_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mips_decode_stage.md
Name: mips_decode_stage

Overview:
- Registered, handshaked decode stage for the pipelined MIPS core; next generation of the combinational control decoder.
- Accepts fetched instructions and produces one registered control bundle plus register indices and extended immediate per instruction.
- Adds load-use stall detection, flush on taken branch/jump, and a sticky syscall-exit halt.
- Sits between the fetch and execute stages.

Parameters:
- XLEN, 32, datapath and instruction width.
- REG_AW, 5, register index width.
- ALUOP_W, 3, ALU operation code width.
- EXIT_CODE, 10, $v0 value that makes SYSCALL halt the stage.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch offers instr_in/pc_in
- in_ready  out  1  stage accepts this cycle
- instr_in  in  XLEN  instruction word
- pc_in  in  XLEN  instruction PC
- flush  in  1  kill the held and incoming instruction
- ex_memread  in  1  instruction in EX is a load
- ex_rt  in  REG_AW  destination of that load
- vreg  in  XLEN  current $v0 value
- out_valid  out  1  bundle valid
- out_ready  in  1  execute stage accepts
- out_pc  out  XLEN  registered PC
- rs, rt, rd  out  REG_AW each  register fields
- imm_ext  out  XLEN  sign-extended imm16; zero-extended for ORI; imm16<<16 for LUI
- reg_dst  out  2  0=rt, 1=rd, 2=r31
- jump, jump_link, jump_reg, branch, branch_ne, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  control
- alu_op  out  ALUOP_W  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- is_syscall, illegal  out  1 each  flags
- halted  out  1  sticky exit indicator

Behaviour:
- Reset: all outputs 0, including out_valid, halted and the bundle; state RUN.
- States: RUN, HALT. HALT is left only by reset.
- Transfer: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Latency: one cycle. The bundle is registered on the input transfer edge.
- Stall detection: hazard = ex_memread && ex_rt != 0 && (ex_rt == instr_in rs, or ex_rt == instr_in rt when the instruction reads rt). Instructions that read rt are R-type, BEQ, BNE and SW.
- Ready rule: in_ready = (state == RUN) && !hazard && !flush && (!out_valid || out_ready).
- Hazard with downstream free: out_valid drops to 0 (a bubble is inserted) and the input is held upstream.
- Backpressure: out_valid && !out_ready holds every output stable.
- flush: out_valid goes to 0 on the next edge and the incoming instruction is not accepted. Priority order: reset, then flush, then everything else.
- Decode table:
  - ADDI/ADDIU/LW/SW/LUI use ADD.
  - ORI uses OR.
  - SLTIU uses SLT.
  - BEQ/BNE use SUB with branch=1; branch_ne=1 for BNE only.
  - J sets jump=1.
  - JAL sets jump, jump_link, reg_write, reg_dst=2.
  - R-type ADD/ADDU/SUB/AND/OR/SLT set reg_dst=1, reg_write=1.
  - JR sets jump_reg=1.
- Unsupported opcode or funct: illegal=1 and every control bit 0. The bundle is still emitted.
- SYSCALL: is_syscall=1 with all control bits 0.
  - If vreg == EXIT_CODE at acceptance, state becomes HALT and halted=1 on the same edge.
  - The syscall bundle itself is emitted and drains normally.
  - In HALT, in_ready=0.
- Simultaneous SYSCALL-exit acceptance and flush: flush wins, no halt.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- When defined, adds outputs stall_cnt (32), bubble_cnt (32) and illegal_cnt (32). All three saturate at 2^32-1 and clear on reset.
  - stall_cnt increments each cycle in_valid && hazard.
  - bubble_cnt increments each cycle a bubble is inserted.
  - illegal_cnt increments per accepted illegal instruction.
- When undefined: no ports and no logic; behaviour otherwise identical.

Decomposition:
- Package mips_pkg holds the opcode and funct constants, the ALU op codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT), and the REGDST_RT/RD/RA encodings.
- One combinational sub-module, mips_ctrl_decode: instr to control bundle, imm_ext, illegal, is_syscall, reads_rt.
- The top holds the registers, handshake, hazard logic and the FSM.

Test Plan:
- After reset, stream ADDI 0x2008000A with out_ready=1 -> next cycle out_valid=1, alu_op=010, alu_src=1, reg_write=1, imm_ext=0x0000000A.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged; release -> next instruction appears one cycle later.
- ex_memread=1, ex_rt=8, instr_in ADD $9,$8,$10 -> in_ready=0 and out_valid=0 for the stall cycle; drop ex_memread -> accepted next edge.
- Assert flush while a BEQ is held -> out_valid=0 next cycle; the instruction offered that cycle is not accepted.
- SYSCALL with vreg=10 -> is_syscall bundle emitted, halted=1, in_ready stays 0 until reset. SYSCALL with vreg=4 -> no halt.
- Opcode 0x3F -> illegal=1, all control 0; with DECODE_PERF_CNT_EN, illegal_cnt=1.
